// File: rtl/axis_block_serializer.sv
// AXI4-Stream block serializer: drains 128-bit blocks from the output block FIFO and
// emits each as four 32-bit beats, most-significant word first, toward the DMA.
module axis_block_serializer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  block_count,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_read_tvalid,
  output logic                  fifo_read_tready,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]  blocks_left_q, blocks_left_d;

  // Next-state logic: job start, block capture, beat shifting and block countdown.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    beat_idx_d    = beat_idx_q;
    blocks_left_d = blocks_left_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (block_count != '0) begin
            blocks_left_d = block_count;
            state_d       = StLoad;
          end else begin
            // Empty job: report completion without touching the FIFO.
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (fifo_read_tvalid) begin
          shift_d    = fifo_rdata;
          beat_idx_d = 2'd0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (m_axis_tready) begin
          shift_d    = shift_q << AXIS_WIDTH;
          beat_idx_d = beat_idx_q + 2'd1;
          if (beat_idx_q == 2'd3) begin
            blocks_left_d = blocks_left_q - CNT_WIDTH'(1);
            state_d       = (blocks_left_q == CNT_WIDTH'(1)) ? StDone : StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      beat_idx_q    <= 2'd0;
      blocks_left_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      beat_idx_q    <= beat_idx_d;
      blocks_left_q <= blocks_left_d;
    end
  end

  // Outputs decode from registered state only; tdata comes straight off the shift register
  // so it cannot change while a beat is stalled.
  always_comb begin
    busy             = (state_q != StIdle);
    done             = (state_q == StDone);
    fifo_read_tready = (state_q == StLoad);
    m_axis_tvalid    = (state_q == StSend);
    m_axis_tdata     = shift_q[DATA_WIDTH-1 -: AXIS_WIDTH];
    m_axis_tlast     = (state_q == StSend) && (beat_idx_q == 2'd3) &&
                       (blocks_left_q == CNT_WIDTH'(1));
  end

endmodule

// File: tb/tb_axis_block_serializer.sv
// Self-checking bench for axis_block_serializer: a FIFO model feeds blocks, a scoreboard
// holds the expected beats and a negedge monitor compares every stream handshake.
module tb_axis_block_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [15:0]  block_count;
  logic         busy;
  logic         done;
  logic [127:0] fifo_rdata;
  logic         fifo_read_tvalid;
  logic         fifo_read_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  axis_block_serializer #(
    .DATA_WIDTH(128),
    .AXIS_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .block_count     (block_count),
    .busy            (busy),
    .done            (done),
    .fifo_rdata      (fifo_rdata),
    .fifo_read_tvalid(fifo_read_tvalid),
    .fifo_read_tready(fifo_read_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [32:0]  exp_q[$];
  logic [127:0] fifo_q[$];
  bit           fifo_hs_pending = 0;
  bit           bp_mode = 0;
  logic [3:0]   bp_pat = 4'b1001;
  int           beat_cnt, done_cnt, fifo_hs_cnt, first_beat_cyc, last_beat_cyc;
  int           tready_hi_cnt, tvalid_hi_cnt;
  bit           prev_stall = 0;
  logic [31:0]  prev_data = '0;

  localparam logic [127:0] SingleBlk = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  // Monitor: sampled on the falling edge, where inputs and outputs are settled for the next
  // rising edge.
  always @(negedge clk) begin
    logic [32:0] got, want;
    cyc++;
    fifo_hs_pending = 0;
    if (reset_n) begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                   m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (m_axis_tvalid) begin
        checks++;
        if (fifo_read_tready !== 1'b0) begin
          errors++;
          $display("FAIL fifo_ready_in_send: fifo_read_tready=%b required 0", fifo_read_tready);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        got = {m_axis_tlast, m_axis_tdata};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got tlast=%b tdata=%h required no beat",
                   got[32], got[31:0]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL beat: got tlast=%b tdata=%h required tlast=%b tdata=%h",
                     got[32], got[31:0], want[32], want[31:0]);
          end
        end
        beat_cnt++;
        if (beat_cnt == 1) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      if (fifo_read_tvalid && fifo_read_tready) begin
        fifo_hs_pending = 1;
        fifo_hs_cnt++;
      end
      if (done) done_cnt++;
      if (fifo_read_tready) tready_hi_cnt++;
      if (m_axis_tvalid) tvalid_hi_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end else begin
      prev_stall = 0;
    end
  end

  // FIFO model and downstream ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (fifo_hs_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_read_tvalid = (fifo_q.size() > 0);
    fifo_rdata       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    m_axis_tready    = bp_mode ? bp_pat[cyc % 4] : 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    beat_cnt = 0; done_cnt = 0; fifo_hs_cnt = 0; first_beat_cyc = 0; last_beat_cyc = 0;
    tready_hi_cnt = 0; tvalid_hi_cnt = 0;
  endtask

  task automatic push_block(input logic [127:0] b, input bit last);
    fifo_q.push_back(b);
    for (int i = 0; i < 4; i++) exp_q.push_back({(last && i == 3), b[127 - 32 * i -: 32]});
  endtask

  task automatic rand_block(output logic [127:0] b);
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic start_job(input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; block_count = n;
    @(posedge clk); #1;
    start = 1'b0; block_count = '0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    tick();
    checks++;
    if ({busy, done, fifo_read_tready, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
        m_axis_tdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b frdy=%b tvalid=%b tlast=%b tdata=%h required all 0",
               busy, done, fifo_read_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_block();
    bit ok;
    tick();
    clear_counts();
    push_block(SingleBlk, 1);
    start_job(16'd1);
    tick();
    checks++;
    if (busy !== 1'b1 || fifo_read_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_start_latency: busy=%b frdy=%b tvalid=%b required 1 1 0",
               busy, fifo_read_tready, m_axis_tvalid);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00112233) begin
      errors++;
      $display("FAIL single_load_latency: tvalid=%b tdata=%h required 1 00112233",
               m_axis_tvalid, m_axis_tdata);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_timeout: done_cnt=%0d required 1", done_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop: busy=%b done=%b required 0 0", busy, done);
    end
    repeat (2) tick();
    checks++;
    if (beat_cnt != 4 || last_beat_cyc - first_beat_cyc != 3 || done_cnt != 1 ||
        fifo_hs_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_counts: beats=%0d span=%0d dones=%0d fifo_hs=%0d left=%0d required 4 3 1 1 0",
               beat_cnt, last_beat_cyc - first_beat_cyc, done_cnt, fifo_hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] b;
    tick();
    clear_counts();
    bp_mode = 1;
    for (int i = 0; i < 3; i++) begin
      rand_block(b);
      push_block(b, i == 2);
    end
    start_job(16'd3);
    wait_done(200, ok);
    checks++;
    if (!ok || beat_cnt != 12 || fifo_hs_cnt != 3 || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_counts: done_ok=%b beats=%0d fifo_hs=%0d dones=%0d left=%0d required 1 12 3 1 0",
               ok, beat_cnt, fifo_hs_cnt, done_cnt, exp_q.size());
    end
    bp_mode = 0;
  endtask

  task automatic test_empty_fifo();
    bit ok;
    logic [127:0] b1, b2;
    tick();
    clear_counts();
    rand_block(b1);
    rand_block(b2);
    push_block(b1, 0);
    start_job(16'd2);
    for (int i = 0; i < 10 && fifo_hs_cnt == 0; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 8) begin
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || fifo_read_tready !== 1'b1) begin
          errors++;
          $display("FAIL empty_fifo_hold: tvalid=%b busy=%b frdy=%b required 0 1 1",
                   m_axis_tvalid, busy, fifo_read_tready);
        end
      end
    end
    push_block(b2, 1);
    wait_done(40, ok);
    checks++;
    if (!ok || beat_cnt != 8 || fifo_hs_cnt != 2 || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL empty_fifo_counts: done_ok=%b beats=%0d fifo_hs=%0d dones=%0d left=%0d required 1 8 2 1 0",
               ok, beat_cnt, fifo_hs_cnt, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero_count();
    tick();
    clear_counts();
    start_job(16'd0);
    tick();
    checks++;
    if (done !== 1'b1 || fifo_read_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b frdy=%b tvalid=%b required 1 0 0",
               done, fifo_read_tready, m_axis_tvalid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: done=%b busy=%b required 0 0", done, busy);
    end
    repeat (3) tick();
    checks++;
    if (tready_hi_cnt != 0 || tvalid_hi_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_counts: frdy_cycles=%0d tvalid_cycles=%0d dones=%0d required 0 0 1",
               tready_hi_cnt, tvalid_hi_cnt, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [127:0] b;
    tick();
    clear_counts();
    for (int i = 0; i < 2; i++) begin
      rand_block(b);
      push_block(b, i == 1);
    end
    start_job(16'd2);
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
    @(posedge clk); #1;
    start = 1'b1; block_count = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; block_count = '0;
    wait_done(40, ok);
    repeat (4) tick();
    checks++;
    if (!ok || beat_cnt != 8 || done_cnt != 1 || busy !== 1'b0 || fifo_hs_cnt != 2 ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_while_busy: done_ok=%b beats=%0d dones=%0d busy=%b fifo_hs=%0d left=%0d required 1 8 1 0 2 0",
               ok, beat_cnt, done_cnt, busy, fifo_hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    logic [127:0] b;
    tick();
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      rand_block(b);
      push_block(b, i == 3);
    end
    start_job(16'd4);
    for (int i = 0; i < 20 && beat_cnt < 3; i++) tick();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    tick();
    checks++;
    if ({busy, done, fifo_read_tready, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
        m_axis_tdata !== 32'h0 || beat_cnt != 3) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b frdy=%b tvalid=%b tlast=%b tdata=%h beats=%0d required 0s and 3 beats",
               busy, done, fifo_read_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, beat_cnt);
    end
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    test_single_block();
  endtask

  initial begin
    reset_n          = 1'b0;
    start            = 1'b0;
    block_count      = '0;
    fifo_rdata       = '0;
    fifo_read_tvalid = 1'b0;
    m_axis_tready    = 1'b1;
    test_reset();
    test_single_block();
    test_backpressure();
    test_empty_fifo();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_block_serializer.md
# axis_block_serializer

Drains 128-bit AES blocks from the output block FIFO and emits each one as four 32-bit beats on an AXI4-Stream master port toward the DMA. A job is started by a one-cycle `start` pulse carrying the job's block count. `m_axis_tlast` is asserted on the final beat of the final block. The block sits directly downstream of the BRAM FIFO and consumes its TVALID/TREADY read port.

## Interface
- `DATA_WIDTH`, default 128: FIFO block width. Must equal 4 × `AXIS_WIDTH`.
- `AXIS_WIDTH`, default 32: stream beat width.
- `CNT_WIDTH`, default 16: width of the block counter.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle job start; sampled only in IDLE.
- `block_count`  in  CNT_WIDTH  number of blocks in the job; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the job's last beat handshake.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data; valid while `fifo_read_tvalid` is high.
- `fifo_read_tvalid`  in  1  FIFO has a block presented.
- `fifo_read_tready`  out  1  serializer accepts the presented block.
- `m_axis_tdata`  out  AXIS_WIDTH  stream beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream accepts the beat.
- `m_axis_tlast`  out  1  last beat of the job.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- **IDLE**
  - On `start` with `block_count` ≠ 0: latch `block_count` into `blocks_left`, go to LOAD.
  - On `start` with `block_count` = 0: go to DONE. No FIFO read, no beats.
- **LOAD**
  - `fifo_read_tready` = 1, decoded from state only. It has no combinational path from `fifo_read_tvalid`.
  - On the FIFO handshake (`fifo_read_tvalid` && `fifo_read_tready`): capture `fifo_rdata` into a 128-bit shift register, clear `beat_idx`, go to SEND.
- **SEND**
  - `m_axis_tvalid` = 1; `m_axis_tdata` = shift register [127:96].
  - Beats go out most-significant word first: beat 0 = block[127:96], beat 3 = block[31:0].
  - On each stream handshake: shift the register left by 32 and increment `beat_idx` (2 bits).
  - Handshake on beat 3: decrement `blocks_left`. If the result is 0, go to DONE; otherwise go to LOAD.
- **DONE**: `done` = 1 for exactly one cycle, then go to IDLE.
- `m_axis_tlast` = SEND && `beat_idx` == 3 && `blocks_left` == 1.
- `start` outside IDLE is ignored, including during DONE.
- `m_axis_tdata` is held stable while `m_axis_tvalid` is high and `m_axis_tready` is low (AXI-Stream rule). `m_axis_tvalid` never drops before its handshake.
- Arithmetic:
  - `blocks_left` is unsigned CNT_WIDTH.
  - Maximum job size is 2^CNT_WIDTH − 1 blocks; no wrap is possible because a job never starts at 0.

## Timing
- Reset values (`reset_n` low at a clock edge):
  - State returns to IDLE.
  - `fifo_read_tready`, `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done` = 0.
  - `m_axis_tdata` = 0; shift register, `beat_idx`, `blocks_left` = 0.
- Reset mid-job discards any captured block and the remaining count. A block already handshaked out of the FIFO is lost; the controller must also reset the FIFO.
- Latencies:
  - `start` at edge N: `busy` and `fifo_read_tready` are high from cycle N+1.
  - FIFO handshake at edge N: `m_axis_tvalid` is high with beat 0 from cycle N+1.
- Throughput: 5 cycles per block minimum (1 LOAD + 4 SEND) with `m_axis_tready` held high.
- With an empty FIFO, the block waits in LOAD indefinitely; `busy` stays high.
- With `m_axis_tready` low, the block waits in SEND indefinitely; `fifo_read_tready` stays 0.
- Last-beat handshake at edge N: `done` is high in cycle N+1 and `busy` drops in cycle N+2.

## Test plan
- **Single block.** Reset, `start` with count 1, FIFO presents 0x00112233_445566778899AABB_CCDDEEFF, `m_axis_tready` = 1. Required: beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles; `tlast` only on 0xCCDDEEFF; `done` pulses once; FIFO read handshakes exactly once.
- **Three blocks with backpressure.** Count 3; `m_axis_tready` toggled 1,0,0,1 repeating. Required: 12 beats in order with `tdata` stable while stalled; `tlast` only on beat 12; `fifo_read_tready` never high in SEND.
- **Empty-FIFO stall.** Count 2; the second block appears 20 cycles late. Required: the block holds in LOAD with `m_axis_tvalid` = 0 and `busy` = 1, then resumes; `tlast` on beat 8.
- **Zero-count job.** `start` with `block_count` = 0. Required: `done` high one cycle later; no `fifo_read_tready`; no `m_axis_tvalid`.
- **Start while busy.** Count 2, plus a second `start` with count 5 during SEND. Required: exactly 8 beats and a single `done`; the count 5 is ignored.
- **Reset mid-job.** Pull `reset_n` low after beat 2 of block 1 of a 4-block job. Required: all outputs 0 on the next cycle, state IDLE; a new job with count 1 then behaves exactly as in the single-block case.
